// File: rtl/count_mon_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// count_mon_pkg : shared types and defaults for the ripple-count monitor
// Rev 1.0
// ---------------------------------------------------------------------------
package count_mon_pkg;

   localparam int c_default_width         = 4;
   localparam int c_default_stable_cycles = 2;
   localparam int c_default_wrap_w        = 8;

   typedef enum logic [0:0] {
      INIT  = 1'b0,
      TRACK = 1'b1
   } mon_state_t;

   typedef enum logic [1:0] {
      STEP_UP = 2'd0,
      STEP_DN = 2'd1,
      JUMP    = 2'd2
   } delta_class_t;

   // delta is (new - old) mod 2^width; all-ones means a single down-step
   function automatic delta_class_t classify_delta(input int unsigned delta,
                                                   input int unsigned width);
      int unsigned all_ones;
      all_ones = (32'd1 << width) - 32'd1;
      if (delta == 32'd1)
         return STEP_UP;
      else if (delta == all_ones)
         return STEP_DN;
      else
         return JUMP;
   endfunction

endpackage
`default_nettype wire

// File: rtl/count_sync_monitor_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_stable_filter : two-flop resynchroniser followed by a run-length
// stability filter; stable means cand has been seen STABLE_CYCLES times
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_stable_filter
   import count_mon_pkg::*;
#(
   parameter int WIDTH         = c_default_width,
   parameter int STABLE_CYCLES = c_default_stable_cycles
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] cand,
   output logic             stable
);

   localparam int                 c_run_w   = $clog2(STABLE_CYCLES + 1);
   localparam logic [c_run_w-1:0] c_run_max = c_run_w'(STABLE_CYCLES);
   localparam logic [c_run_w-1:0] c_run_one = c_run_w'(1);

   logic [WIDTH-1:0]   r_s1;
   logic [WIDTH-1:0]   r_s2;
   logic [WIDTH-1:0]   r_cand;
   logic [c_run_w-1:0] r_run;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_cand <= '0;
         r_run  <= '0;
      end else begin
         r_s1 <= din;
         r_s2 <= r_s1;
         if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_run  <= c_run_one;
         end else if (r_run != c_run_max) begin
            r_run <= r_run + c_run_one;
         end
      end
   end

   assign cand   = r_cand;
   assign stable = (r_run == c_run_max);

endmodule
`default_nettype wire

// File: rtl/count_sync_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// count_sync_monitor : filtered view of an asynchronous ripple counter with
// overflow/underflow/match/direction pulses and a saturating wrap tally
// Rev 1.0
// ---------------------------------------------------------------------------
module count_sync_monitor
   import count_mon_pkg::*;
#(
   parameter int WIDTH         = c_default_width,
   parameter int STABLE_CYCLES = c_default_stable_cycles,
   parameter int WRAP_W        = c_default_wrap_w
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              up_down,
   input  logic [WIDTH-1:0]  match_val,
   input  logic              clr_wrap,
   output logic [WIDTH-1:0]  count_q,
   output logic              valid,
   output logic              ovf_pulse,
   output logic              unf_pulse,
   output logic              match_pulse,
   output logic              dir_err,
   output logic [WRAP_W-1:0] wrap_cnt
);

   logic              r_d1;
   logic              r_d2;
   logic [WIDTH-1:0]  w_cand;
   logic              w_stable;
   logic              w_accept;
   logic [WIDTH-1:0]  w_delta;
   delta_class_t      w_class;
   logic              w_ovf_evt;
   logic              w_unf_evt;
   logic              w_wrap_evt;

   mon_state_t        r_state;
   logic [WIDTH-1:0]  r_count_q;
   logic              r_valid;
   logic              r_ovf;
   logic              r_unf;
   logic              r_match;
   logic              r_dir_err;
   logic [WRAP_W-1:0] r_wrap_cnt;

   sync_stable_filter #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk    (clk),
      .reset  (reset),
      .din    (count_in),
      .cand   (w_cand),
      .stable (w_stable)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_d1 <= 1'b0;
         r_d2 <= 1'b0;
      end else begin
         r_d1 <= up_down;
         r_d2 <= r_d1;
      end
   end

   // Once tracking, an already-accepted cand must not re-trigger pulses
   assign w_accept   = w_stable && ((r_state == INIT) || (w_cand != r_count_q));
   assign w_delta    = w_cand - r_count_q;
   assign w_class    = classify_delta(32'(w_delta), WIDTH);
   assign w_ovf_evt  = (r_state == TRACK) && w_accept && (w_class == STEP_UP) && (r_count_q == '1);
   assign w_unf_evt  = (r_state == TRACK) && w_accept && (w_class == STEP_DN) && (r_count_q == '0);
   assign w_wrap_evt = w_ovf_evt || w_unf_evt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= INIT;
         r_count_q <= '0;
         r_valid   <= 1'b0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
         r_match   <= 1'b0;
         r_dir_err <= 1'b0;
      end else begin
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
         r_match   <= 1'b0;
         r_dir_err <= 1'b0;
         case (r_state)
            INIT: begin
               if (w_accept) begin
                  r_count_q <= w_cand;
                  r_valid   <= 1'b1;
                  r_state   <= TRACK;
               end
            end
            TRACK: begin
               if (w_accept) begin
                  r_count_q <= w_cand;
                  r_match   <= (w_cand == match_val);
                  r_ovf     <= w_ovf_evt;
                  r_unf     <= w_unf_evt;
                  case (w_class)
                     STEP_UP: r_dir_err <= ~r_d2;
                     STEP_DN: r_dir_err <= r_d2;
                     default: r_dir_err <= 1'b1;
                  endcase
               end
            end
            default: r_state <= INIT;
         endcase
      end
   end

   // Updates on the same edge that registers the ovf/unf pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrap_cnt <= '0;
      end else if (clr_wrap) begin
         r_wrap_cnt <= w_wrap_evt ? WRAP_W'(1) : '0;
      end else if (w_wrap_evt && (r_wrap_cnt != '1)) begin
         r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
      end
   end

   assign count_q     = r_count_q;
   assign valid       = r_valid;
   assign ovf_pulse   = r_ovf;
   assign unf_pulse   = r_unf;
   assign match_pulse = r_match;
   assign dir_err     = r_dir_err;
   assign wrap_cnt    = r_wrap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_count_sync_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_count_sync_monitor : randomized and directed bench with a segment-level
// reference model of the monitor
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_count_sync_monitor;

   localparam int W    = 4;
   localparam int MOD  = 16;
   localparam int WMAX = 255;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] count_in;
   logic         up_down;
   logic [W-1:0] match_val;
   logic         clr_wrap;
   logic [W-1:0] count_q;
   logic         valid;
   logic         ovf_pulse;
   logic         unf_pulse;
   logic         match_pulse;
   logic         dir_err;
   logic [7:0]   wrap_cnt;

   int checks = 0;
   int errors = 0;
   int m_q, m_valid, m_wrap;
   int n_ovf, n_unf, n_dir, n_match;

   count_sync_monitor #(.WIDTH(4), .STABLE_CYCLES(2), .WRAP_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .count_in    (count_in),
      .up_down     (up_down),
      .match_val   (match_val),
      .clr_wrap    (clr_wrap),
      .count_q     (count_q),
      .valid       (valid),
      .ovf_pulse   (ovf_pulse),
      .unf_pulse   (unf_pulse),
      .match_pulse (match_pulse),
      .dir_err     (dir_err),
      .wrap_cnt    (wrap_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // One held input value, optionally preceded by a single-cycle transient.
   // The new value is visible on the 6th falling edge after it is driven.
   task automatic seg(input int v, input bit ud, input bit use_g, input int g,
                      input int hold, input bit clr_at_acc);
      bit acc;
      int delta, e_q, e_ovf, e_unf, e_dir, e_match, e_wrap;
      int x_q, x_v, x_o, x_u, x_m, x_d, x_w;
      acc = (m_valid == 0) || (v != m_q);
      e_q = acc ? v : m_q;
      e_ovf = 0; e_unf = 0; e_dir = 0; e_match = 0;
      if (acc && m_valid != 0) begin
         delta = ((v - m_q) % MOD + MOD) % MOD;
         if (delta == 1) begin
            e_dir = !ud; e_ovf = (m_q == MOD - 1);
         end else if (delta == MOD - 1) begin
            e_dir = ud;  e_unf = (m_q == 0);
         end else begin
            e_dir = 1;
         end
         e_match = (v == int'(match_val));
      end
      if (e_ovf != 0 || e_unf != 0)
         e_wrap = clr_at_acc ? 1 : ((m_wrap < WMAX) ? m_wrap + 1 : WMAX);
      else
         e_wrap = clr_at_acc ? 0 : m_wrap;

      @(posedge clk); #1;
      up_down = ud;
      if (use_g) begin
         count_in = W'(g);
         @(posedge clk); #1;
      end
      count_in = W'(v);
      for (int k = 1; k <= hold; k++) begin
         @(negedge clk);
         if (k < 6) begin
            x_q = m_q; x_v = m_valid; x_o = 0; x_u = 0; x_m = 0; x_d = 0; x_w = m_wrap;
         end else if (k == 6) begin
            x_q = e_q; x_v = 1; x_o = e_ovf; x_u = e_unf; x_m = e_match; x_d = e_dir; x_w = e_wrap;
         end else begin
            x_q = e_q; x_v = 1; x_o = 0; x_u = 0; x_m = 0; x_d = 0; x_w = e_wrap;
         end
         checks++;
         if ({count_q, valid, ovf_pulse, unf_pulse, match_pulse, dir_err} !==
             {W'(x_q), x_v[0], x_o[0], x_u[0], x_m[0], x_d[0]}) begin
            errors++;
            $display("FAIL seg_outputs v=%0d k=%0d got q=%0d val=%0b ovf=%0b unf=%0b m=%0b dir=%0b exp q=%0d val=%0d ovf=%0d unf=%0d m=%0d dir=%0d",
                     v, k, count_q, valid, ovf_pulse, unf_pulse, match_pulse, dir_err,
                     x_q, x_v, x_o, x_u, x_m, x_d);
         end
         checks++;
         if (wrap_cnt !== 8'(x_w)) begin
            errors++;
            $display("FAIL seg_wrap v=%0d k=%0d got %0d exp %0d", v, k, wrap_cnt, x_w);
         end
         n_ovf += int'(ovf_pulse); n_unf += int'(unf_pulse);
         n_dir += int'(dir_err);   n_match += int'(match_pulse);
         if (clr_at_acc && k == 5) clr_wrap = 1'b1;
         if (k == 6) clr_wrap = 1'b0;
      end
      m_q = e_q; m_valid = 1; m_wrap = e_wrap;
   endtask

   task automatic release_and_init(output int rise_k);
      rise_k = 0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (valid === 1'b1 && rise_k == 0) rise_k = k;
      end
      m_q = 0; m_valid = 1; m_wrap = 0;
   endtask

   task automatic test_reset();
      int rk;
      reset = 1'b1; count_in = '0; up_down = 1'b0; match_val = '0; clr_wrap = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({count_q, valid, ovf_pulse, unf_pulse, match_pulse, dir_err, wrap_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_state got q=%0d val=%0b wrap=%0d exp all zero", count_q, valid, wrap_cnt);
      end
      release_and_init(rk);
      checks++;
      if (rk < 3 || rk > 4) begin
         errors++;
         $display("FAIL reset_valid_latency got edge %0d exp 3..4", rk);
      end
      checks++;
      if ({count_q, ovf_pulse, unf_pulse, match_pulse, dir_err} !== '0 || n_match + n_dir != 0) begin
         errors++;
         $display("FAIL reset_init_outputs got q=%0d dir=%0d match=%0d exp 0", count_q, n_dir, n_match);
      end
      seg(5, 1'b1, 1'b0, 0, 8, 1'b0);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({count_q, valid, ovf_pulse, unf_pulse, match_pulse, dir_err, wrap_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_midrun got q=%0d val=%0b exp 0 0", count_q, valid);
      end
      count_in = '0;
      release_and_init(rk);
      checks++;
      if (valid !== 1'b1 || count_q !== '0) begin
         errors++;
         $display("FAIL reset_reinit got val=%0b q=%0d exp 1 0", valid, count_q);
      end
      n_ovf = 0; n_unf = 0; n_dir = 0; n_match = 0;
   endtask

   task automatic test_overflow();
      int o0, d0;
      o0 = n_ovf; d0 = n_dir;
      match_val = 4'd1;
      seg(13, 1'b1, 1'b0, 0, 10, 1'b0);
      d0 = n_dir;
      seg(14, 1'b1, 1'b0, 0, 10, 1'b0);
      seg(15, 1'b1, 1'b0, 0, 10, 1'b0);
      seg(0,  1'b1, 1'b0, 0, 10, 1'b0);
      checks++;
      if (n_ovf - o0 != 1 || wrap_cnt !== 8'd1 || n_dir != d0) begin
         errors++;
         $display("FAIL overflow got ovf=%0d wrap=%0d dir=%0d exp 1 1 0", n_ovf - o0, wrap_cnt, n_dir - d0);
      end
   endtask

   task automatic test_underflow();
      int u0, d0;
      seg(1, 1'b0, 1'b0, 0, 10, 1'b0);
      u0 = n_unf; d0 = n_dir;
      seg(0,  1'b0, 1'b0, 0, 10, 1'b0);
      seg(15, 1'b0, 1'b0, 0, 10, 1'b0);
      checks++;
      if (n_unf - u0 != 1 || wrap_cnt !== 8'd2 || n_dir != d0) begin
         errors++;
         $display("FAIL underflow got unf=%0d wrap=%0d dir=%0d exp 1 2 0", n_unf - u0, wrap_cnt, n_dir - d0);
      end
   endtask

   task automatic test_glitch();
      int d0;
      seg(7, 1'b1, 1'b0, 0, 10, 1'b0);
      d0 = n_dir;
      seg(8, 1'b1, 1'b1, 6, 10, 1'b0);
      checks++;
      if (count_q !== 4'd8 || n_dir != d0) begin
         errors++;
         $display("FAIL glitch got q=%0d dir=%0d exp 8 0", count_q, n_dir - d0);
      end
      d0 = n_dir;
      seg(8, 1'b1, 1'b1, 3, 10, 1'b0);
      checks++;
      if (count_q !== 4'd8 || n_dir != d0) begin
         errors++;
         $display("FAIL glitch_return got q=%0d dir=%0d exp 8 0", count_q, n_dir - d0);
      end
   endtask

   task automatic test_dir_jump_match();
      int d0, o0, m0;
      match_val = 4'd0;
      seg(3, 1'b1, 1'b0, 0, 10, 1'b0);
      d0 = n_dir;
      seg(2, 1'b1, 1'b0, 0, 10, 1'b0);
      checks++;
      if (n_dir - d0 != 1) begin
         errors++;
         $display("FAIL dir_against got %0d exp 1", n_dir - d0);
      end
      match_val = 4'd9;
      d0 = n_dir; o0 = n_ovf + n_unf; m0 = n_match;
      seg(9, 1'b1, 1'b0, 0, 10, 1'b0);
      checks++;
      if (n_dir - d0 != 1 || n_ovf + n_unf != o0 || n_match - m0 != 1 || count_q !== 4'd9) begin
         errors++;
         $display("FAIL jump_match got dir=%0d wraps=%0d match=%0d q=%0d exp 1 0 1 9",
                  n_dir - d0, n_ovf + n_unf - o0, n_match - m0, count_q);
      end
   endtask

   task automatic test_wrap_sat();
      int v;
      while (m_wrap < WMAX) begin
         v = (m_q == 15) ? 0 : 15;
         seg(v, (v == 0), 1'b0, 0, 7, 1'b0);
      end
      for (int i = 0; i < 2; i++) begin
         v = (m_q == 15) ? 0 : 15;
         seg(v, (v == 0), 1'b0, 0, 7, 1'b0);
      end
      checks++;
      if (wrap_cnt !== 8'd255) begin
         errors++;
         $display("FAIL wrap_saturate got %0d exp 255", wrap_cnt);
      end
      if (m_q != 15) seg(15, 1'b0, 1'b0, 0, 8, 1'b0);
      seg(0, 1'b1, 1'b0, 0, 8, 1'b1);
      checks++;
      if (wrap_cnt !== 8'd1) begin
         errors++;
         $display("FAIL wrap_clr_with_ovf got %0d exp 1", wrap_cnt);
      end
      @(negedge clk); clr_wrap = 1'b1;
      @(negedge clk); clr_wrap = 1'b0;
      m_wrap = 0;
      checks++;
      if (wrap_cnt !== 8'd0) begin
         errors++;
         $display("FAIL wrap_clr_alone got %0d exp 0", wrap_cnt);
      end
   endtask

   task automatic test_random();
      int v, g;
      bit ug, cl;
      for (int i = 0; i < 150; i++) begin
         v  = int'($urandom_range(0, 15));
         ug = ($urandom_range(0, 2) == 0);
         g  = int'($urandom_range(0, 15));
         if (g == v) g = (g + 1) % MOD;
         cl = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) v = (m_q + 1) % MOD;
         else if ($urandom_range(0, 3) == 0) v = (m_q + MOD - 1) % MOD;
         if (g == v) g = (g + 1) % MOD;
         match_val = W'($urandom_range(0, 15));
         seg(v, 1'($urandom_range(0, 1)), ug, g, int'($urandom_range(7, 10)), cl);
      end
   endtask

   initial begin
      n_ovf = 0; n_unf = 0; n_dir = 0; n_match = 0;
      m_q = 0; m_valid = 0; m_wrap = 0;
      test_reset();
      test_overflow();
      test_underflow();
      test_glitch();
      test_dir_jump_match();
      test_wrap_sat();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
